lfsr_arbiter: RTL and testbench



---
 rtl/lfsr_arbiter.sv | 131 +++++++++++++
 tb/tb_lfsr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter that hands out values from one shared 8-bit LFSR, one value per grant.
// Supports runtime reseeding followed by a fixed warm-up that discards the first steps.
module lfsr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WARMUP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [7:0]       seed_in,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [7:0]       rnd_out,
    output logic             rnd_valid,
    output logic             busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic {
        ST_SERVE  = 1'b0,
        ST_WARMUP = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       lfsr_reg, lfsr_next;
    logic [PW-1:0]    ptr_reg, ptr_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic [7:0]       rnd_reg, rnd_next;

    logic [7:0]       lfsr_step;
    logic [7:0]       seed_safe;
    logic [PW-1:0]    cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;
    logic             sel_valid;
    logic [PW-1:0]    sel_idx;
    logic [PW-1:0]    ptr_wrap;

    assign lfsr_step = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5]};
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_safe = (seed_in == 8'h00) ? 8'h01 : seed_in;

    // Candidate gi is the requester gi positions past the pointer, modulo N_REQ.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [PW:0] sum;
            assign sum          = {1'b0, ptr_reg} + (PW+1)'(gi);
            assign cand_idx[gi] = (sum >= (PW+1)'(N_REQ)) ? PW'(sum - (PW+1)'(N_REQ))
                                                           : sum[PW-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the far end so the nearest candidate to the pointer wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx[i];
            end
        end
    end

    assign ptr_wrap = (sel_idx == PW'(N_REQ - 1)) ? '0 : sel_idx + PW'(1);

    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        gnt_next   = '0;
        rnd_next   = rnd_reg;
        case (state_reg)
            ST_SERVE: begin
                if (seed_load) begin
                    lfsr_next  = seed_safe;
                    cnt_next   = '0;
                    state_next = ST_WARMUP;
                end else if (sel_valid) begin
                    gnt_next  = N_REQ'(1) << sel_idx;
                    rnd_next  = lfsr_reg;
                    lfsr_next = lfsr_step;
                    ptr_next  = ptr_wrap;
                end
            end
            ST_WARMUP: begin
                if (seed_load) begin
                    lfsr_next = seed_safe;
                    cnt_next  = '0;
                end else begin
                    lfsr_next = lfsr_step;
                    if (cnt_reg == CW'(WARMUP - 1)) begin
                        cnt_next   = '0;
                        state_next = ST_SERVE;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end
            default: state_next = ST_SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_SERVE;
            lfsr_reg  <= 8'h01;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
            gnt_reg   <= '0;
            rnd_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            gnt_reg   <= gnt_next;
            rnd_reg   <= rnd_next;
        end
    end

    assign gnt       = gnt_reg;
    assign rnd_out   = rnd_reg;
    assign rnd_valid = |gnt_reg;
    assign busy      = (state_reg == ST_WARMUP);

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Scoreboard bench for lfsr_arbiter: directed cases from the plan plus randomized traffic
// checked against a behavioural model (sequence arithmetic and modulo round-robin search).
module tb_lfsr_arbiter;

    localparam int N = 4;
    localparam int WU = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         seed_load = 1'b0;
    logic [7:0]   seed_in = 8'h00;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [7:0]   rnd_out;
    logic         rnd_valid;
    logic         busy;

    lfsr_arbiter #(.N_REQ(N), .WARMUP(WU)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
        .req(req), .gnt(gnt), .rnd_out(rnd_out), .rnd_valid(rnd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic busy; logic valid; logic [7:0] rnd; } cyc_t;
    typedef struct { logic [N-1:0] g; logic [7:0] rnd; } gnt_t;

    cyc_t cyc_q[$];
    gnt_t gnt_q[$];
    gnt_t seen_q[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0] m_lfsr;
    logic [7:0] m_rnd;
    int         m_ptr;
    int         m_warm_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        int fb;
        fb = ((v >> 7) ^ (v >> 5)) & 1;
        return 8'(((v * 2) & 8'hFE) | fb);
    endfunction

    function automatic void model_reset();
        m_lfsr = 8'h01;
        m_rnd = 8'h00;
        m_ptr = 0;
        m_warm_left = 0;
    endfunction

    // Drive one edge of stimulus and push the model's expectation for it.
    task automatic step(input logic sl, input logic [7:0] sd, input logic [N-1:0] rq);
        logic [N-1:0] g;
        cyc_t c;
        gnt_t e;
        @(negedge clk);
        seed_load = sl;
        seed_in = sd;
        req = rq;
        g = '0;
        if (sl) begin
            m_lfsr = (sd == 8'h00) ? 8'h01 : sd;
            m_warm_left = WU;
        end else if (m_warm_left > 0) begin
            m_lfsr = lfsr_adv(m_lfsr);
            m_warm_left--;
        end else begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g == '0 && rq[idx]) begin
                    g = N'(1) << idx;
                    m_rnd = m_lfsr;
                    m_lfsr = lfsr_adv(m_lfsr);
                    m_ptr = (idx + 1) % N;
                end
            end
        end
        c.busy = (m_warm_left > 0);
        c.valid = (g != '0);
        c.rnd = m_rnd;
        cyc_q.push_back(c);
        if (g != '0) begin
            e.g = g;
            e.rnd = m_rnd;
            gnt_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        seed_load = 1'b0;
        req = '0;
        #1;
        chk("reset gnt", 32'(gnt), 0);
        chk("reset rnd_out", 32'(rnd_out), 0);
        chk("reset rnd_valid", 32'(rnd_valid), 0);
        chk("reset busy", 32'(busy), 0);
        model_reset();
        seen_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic chk_seen(input string name, input int idx, input logic [N-1:0] g,
                            input logic [7:0] r);
        if (idx >= seen_q.size()) begin
            chk({name, " missing"}, 32'(seen_q.size()), 32'(idx + 1));
        end else begin
            chk({name, " gnt"}, 32'(seen_q[idx].g), 32'(g));
            chk({name, " rnd"}, 32'(seen_q[idx].rnd), 32'(r));
        end
    endtask

    // Monitor: per-cycle status plus grant scoreboard
    initial begin
        cyc_t c;
        gnt_t e;
        gnt_t s;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() != 0) begin
                c = cyc_q.pop_front();
                chk("busy", 32'(busy), 32'(c.busy));
                chk("rnd_valid", 32'(rnd_valid), 32'(c.valid));
                chk("rnd_out held", 32'(rnd_out), 32'(c.rnd));
            end
            if (rnd_valid) begin
                s.g = gnt;
                s.rnd = rnd_out;
                seen_q.push_back(s);
                if (gnt_q.size() == 0) begin
                    chk("unexpected grant", 32'(gnt), 0);
                end else begin
                    e = gnt_q.pop_front();
                    chk("grant gnt", 32'(gnt), 32'(e.g));
                    chk("grant rnd", 32'(rnd_out), 32'(e.rnd));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_cycles;
        model_reset();
        do_reset();

        // Single requester, one value per cycle
        repeat (3) step(1'b0, 8'h00, 4'b0001);
        step(1'b0, 8'h00, 4'b0000);
        chk_seen("t1 g0", 0, 4'b0001, 8'h01);
        chk_seen("t1 g1", 1, 4'b0001, 8'h02);
        chk_seen("t1 g2", 2, 4'b0001, 8'h04);

        // All requesting: rotation with wrap
        do_reset();
        repeat (5) step(1'b0, 8'h00, 4'b1111);
        step(1'b0, 8'h00, 4'b0000);
        chk_seen("t2 g0", 0, 4'b0001, 8'h01);
        chk_seen("t2 g1", 1, 4'b0010, 8'h02);
        chk_seen("t2 g2", 2, 4'b0100, 8'h04);
        chk_seen("t2 g3", 3, 4'b1000, 8'h08);
        chk_seen("t2 g4", 4, 4'b0001, 8'h10);

        // Sparse requests skip idle indices
        do_reset();
        repeat (3) step(1'b0, 8'h00, 4'b1010);
        step(1'b0, 8'h00, 4'b0000);
        chk_seen("t3 g0", 0, 4'b0010, 8'h01);
        chk_seen("t3 g1", 1, 4'b1000, 8'h02);
        chk_seen("t3 g2", 2, 4'b0010, 8'h04);

        // Zero seed replaced by 1, then warm-up
        do_reset();
        step(1'b1, 8'h00, 4'b0001);
        busy_cycles = 0;
        repeat (WU) begin
            #6;
            if (busy) busy_cycles++;
            step(1'b0, 8'h00, 4'b0001);
        end
        chk("t4 busy cycles", 32'(busy_cycles), 32'(WU));
        repeat (2) step(1'b0, 8'h00, 4'b0001);
        step(1'b0, 8'h00, 4'b0000);
        chk_seen("t4 g0", 0, 4'b0001, 8'h05);
        chk_seen("t4 g1", 1, 4'b0001, 8'h0A);

        // Seed wins over a simultaneous request
        do_reset();
        step(1'b1, 8'h5A, 4'b0100);
        repeat (WU + 2) step(1'b0, 8'h00, 4'b0100);
        step(1'b0, 8'h00, 4'b0000);
        chk("t5 grant count", 32'(seen_q.size()), 2);
        if (seen_q.size() > 0) chk("t5 first gnt", 32'(seen_q[0].g), 32'(4'b0100));

        // Reset in the middle of warm-up
        do_reset();
        step(1'b1, 8'h33, 4'b0000);
        repeat (3) step(1'b0, 8'h00, 4'b0000);
        #6;
        chk("t6 busy before reset", 32'(busy), 1);
        do_reset();
        step(1'b0, 8'h00, 4'b0001);
        step(1'b0, 8'h00, 4'b0000);
        chk_seen("t6 g0", 0, 4'b0001, 8'h01);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic sl;
            logic [7:0] sd;
            if ($urandom_range(0, 399) == 0) do_reset();
            sl = ($urandom_range(0, 39) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step(sl, sd, N'($urandom));
        end
        step(1'b0, 8'h00, 4'b0000);
        step(1'b0, 8'h00, 4'b0000);
        chk("grant queue drained", 32'(gnt_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
